// File: rtl/axi_rd_burst_sched_pkg.sv
// Shared constants for the AXI read burst scheduler: FSM encoding, AXI burst type
// and the page size a single burst must never cross.
package axi_rd_burst_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_CALC  = 2'd2;
  localparam state_t ST_ISSUE = 2'd3;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned BOUNDARY_4K    = 4096;

  function automatic logic [2:0] axi_size_of(input int unsigned beat_bytes);
    return 3'($clog2(beat_bytes));
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Beats for the next burst: the smallest of remaining beats, the burst cap and the
// beats left before the next 4 KB page. Purely combinational; the parent registers it.
module axi_burst_len_calc
  import axi_rd_burst_sched_pkg::*;
#(
  parameter int LEN_W      = 32,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic [11:0]      i_page_off,
  input  logic [LEN_W-1:0] i_rem_beats,
  output logic [8:0]       o_beats
);

  localparam int SH = $clog2(BEAT_BYTES);
  localparam int CW = (LEN_W > 14) ? LEN_W : 14;

  logic [CW-1:0] w_page_beats;
  logic [CW-1:0] w_rem;
  logic [CW-1:0] w_cap;
  logic [CW-1:0] w_min_rc;
  logic [CW-1:0] w_min_all;

  always_comb begin
    w_page_beats = (CW'(BOUNDARY_4K) - CW'(i_page_off)) >> SH;
    w_rem        = CW'(i_rem_beats);
    w_cap        = CW'(MAX_BURST);
    w_min_rc     = (w_rem < w_cap) ? w_rem : w_cap;
    w_min_all    = (w_min_rc < w_page_beats) ? w_min_rc : w_page_beats;
    o_beats      = 9'(w_min_all);
  end

endmodule

// File: rtl/axi_rd_burst_sched.sv
// Splits {addr, len_bytes} descriptors from a FWFT FIFO into AXI INCR read bursts,
// capped in length and at 4 KB pages, with a limit on outstanding bursts.
module axi_rd_burst_sched
  import axi_rd_burst_sched_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 32,
  parameter int BEAT_BYTES   = 8,
  parameter int MAX_BURST    = 16,
  parameter int MAX_OUTS     = 4,
  parameter int OUTS_CNT_WID = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic [ADDR_W+LEN_W-1:0]  fifo_data,
  output logic                     fifo_pop,
  output logic                     ar_valid,
  input  logic                     ar_ready,
  output logic [ADDR_W-1:0]        ar_addr,
  output logic [7:0]               ar_len,
  output logic [2:0]               ar_size,
  output logic [1:0]               ar_burst,
  input  logic                     r_last_hs,
  output logic [OUTS_CNT_WID-1:0]  outs_cnt,
  output logic                     busy,
  output logic                     desc_done
);

  localparam int SH = $clog2(BEAT_BYTES);

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_cur_addr;
  logic [LEN_W-1:0]         r_rem_beats;
  logic [8:0]               r_beats;
  logic [7:0]               r_ar_len;
  logic [OUTS_CNT_WID-1:0]  r_outs_cnt;

  logic [ADDR_W-1:0] w_fifo_addr;
  logic [LEN_W-1:0]  w_fifo_len;
  logic [8:0]        w_beats;
  logic              w_ar_hs;
  logic              w_last_burst;
  logic              w_inc;
  logic              w_dec;

  assign w_fifo_addr = fifo_data[ADDR_W+LEN_W-1:LEN_W];
  assign w_fifo_len  = fifo_data[LEN_W-1:0];

  axi_burst_len_calc #(
    .LEN_W      (LEN_W),
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BURST  (MAX_BURST)
  ) u_len_calc (
    .i_page_off  (r_cur_addr[11:0]),
    .i_rem_beats (r_rem_beats),
    .o_beats     (w_beats)
  );

  // Pop is gated by rst so it stays low while the FSM is being held in reset.
  assign fifo_pop     = !rst && (r_state == ST_IDLE) && !fifo_empty;
  assign ar_valid     = (r_state == ST_ISSUE) && (r_outs_cnt < OUTS_CNT_WID'(MAX_OUTS));
  assign w_ar_hs      = ar_valid && ar_ready;
  assign w_last_burst = (r_rem_beats == LEN_W'(r_beats));
  assign desc_done    = ((r_state == ST_LOAD) && (r_rem_beats == '0)) ||
                        (w_ar_hs && w_last_burst);

  assign ar_addr  = r_cur_addr;
  assign ar_len   = r_ar_len;
  assign ar_size  = axi_size_of(BEAT_BYTES);
  assign ar_burst = AXI_BURST_INCR;
  assign outs_cnt = r_outs_cnt;
  assign busy     = (r_state != ST_IDLE) || (r_outs_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= '0;
      r_rem_beats <= '0;
      r_beats     <= '0;
      r_ar_len    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fifo_pop) begin
            r_cur_addr  <= w_fifo_addr & ~ADDR_W'(BEAT_BYTES - 1);
            r_rem_beats <= w_fifo_len >> SH;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= (r_rem_beats == '0) ? ST_IDLE : ST_CALC;
        end
        ST_CALC: begin
          r_beats  <= w_beats;
          r_ar_len <= 8'(w_beats - 9'd1);
          r_state  <= ST_ISSUE;
        end
        default: begin
          if (w_ar_hs) begin
            r_cur_addr  <= r_cur_addr + (ADDR_W'(r_beats) << SH);
            r_rem_beats <= r_rem_beats - LEN_W'(r_beats);
            r_state     <= w_last_burst ? ST_IDLE : ST_CALC;
          end
        end
      endcase
    end
  end

  // A retire with nothing outstanding is a stray pulse and is dropped.
  assign w_inc = w_ar_hs;
  assign w_dec = r_last_hs && (r_outs_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outs_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_outs_cnt <= r_outs_cnt + 1'b1;
    end else if (w_dec && !w_inc) begin
      r_outs_cnt <= r_outs_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_sched.sv
// Randomized bench for axi_rd_burst_sched: descriptors feed a FIFO model, expected
// AR bursts come from a page/length reference model and are checked by a monitor.
module tb_axi_rd_burst_sched;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;
  localparam int BB     = 8;
  localparam int MAXB   = 16;
  localparam int MAXO   = 4;

  typedef struct {
    bit          zero;
    logic [31:0] addr;
    logic [7:0]  len;
    bit          last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [63:0] fifo_data;
  logic        fifo_pop;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_last_hs;
  logic [2:0]  outs_cnt;
  logic        busy;
  logic        desc_done;

  logic [63:0] desc_q[$];
  ev_t         exp_q[$];

  int checks = 0;
  int errors = 0;
  int m_outs = 0;
  int ar_cnt = 0;
  int both_cnt = 0;
  int stab_cnt = 0;

  int rdy_pct   = 100;
  int rl_pct    = 50;
  bit rl_follow = 0;
  bit rl_once   = 0;

  axi_rd_burst_sched #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BEAT_BYTES(BB),
    .MAX_BURST(MAXB), .MAX_OUTS(MAXO), .OUTS_CNT_WID(3)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_last_hs(r_last_hs), .outs_cnt(outs_cnt), .busy(busy), .desc_done(desc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: split a descriptor into page-safe, capped bursts.
  task automatic push_desc(input logic [31:0] addr_raw, input logic [31:0] len_raw);
    logic [31:0] a;
    longint      rem;
    longint      room;
    longint      b;
    ev_t         e;
    a   = addr_raw & ~32'(BB - 1);
    rem = longint'(len_raw) / BB;
    if (rem == 0) begin
      e.zero = 1; e.addr = '0; e.len = '0; e.last = 1;
      exp_q.push_back(e);
    end
    while (rem > 0) begin
      room = (4096 - longint'(a % 4096)) / BB;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      e.zero = 0; e.addr = a; e.len = 8'(b - 1); e.last = (rem == b);
      exp_q.push_back(e);
      a   = a + 32'(b * BB);
      rem = rem - b;
    end
    desc_q.push_back({addr_raw, len_raw});
  endtask

  // FIFO and AXI-side driver: inputs change 1 time unit after the rising edge.
  initial begin : driver
    bit pop_s;
    forever begin
      @(negedge clk);
      pop_s = fifo_pop;
      @(posedge clk);
      #1;
      if (pop_s && desc_q.size() != 0) void'(desc_q.pop_front());
      fifo_empty = (desc_q.size() == 0);
      fifo_data  = fifo_empty ? {$urandom, $urandom} : desc_q[0];
      ar_ready   = ($urandom_range(0, 99) < rdy_pct);
      if (rl_once) begin
        r_last_hs = 1'b1;
        rl_once   = 0;
      end else if (rl_follow) begin
        r_last_hs = ar_valid;
      end else begin
        r_last_hs = ($urandom_range(0, 99) < rl_pct);
      end
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin : monitor
    bit          prev_stall = 0;
    bit          prev_pop   = 0;
    logic [31:0] prev_addr  = '0;
    logic [7:0]  prev_len   = '0;
    bit          hs;
    ev_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        prev_pop   = 0;
      end else begin
        hs = ar_valid && ar_ready;
        if (fifo_empty) chk("pop_while_empty", fifo_pop, 0);
        chk("outs_cnt", outs_cnt, m_outs);
        if (m_outs != 0) chk("busy_outstanding", busy, 1);
        if (prev_stall) begin
          stab_cnt++;
          chk("hold_valid", ar_valid, 1);
          chk("hold_addr", ar_addr, prev_addr);
          chk("hold_len", ar_len, prev_len);
        end
        if (hs) begin
          ar_cnt++;
          chk("ar_size", ar_size, 3);
          chk("ar_burst", ar_burst, 1);
          chk("page_cross", (32'(ar_addr[11:0]) + (32'(ar_len) + 1) * BB) <= 4096, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_ar", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("ar_kind", e.zero, 0);
            chk("ar_addr", ar_addr, e.addr);
            chk("ar_len", ar_len, e.len);
            chk("done_on_hs", desc_done, e.last);
          end
        end else if (desc_done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("zero_len_done", e.zero, 1);
            chk("zero_done_after_pop", prev_pop, 1);
          end
        end
        if (hs && r_last_hs && m_outs != 0) both_cnt++;
        m_outs = m_outs + (hs ? 1 : 0) - ((r_last_hs && m_outs != 0) ? 1 : 0);
        prev_stall = ar_valid && !ar_ready;
        prev_addr  = ar_addr;
        prev_len   = ar_len;
        prev_pop   = fifo_pop;
      end
    end
  end

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || desc_q.size() != 0 || m_outs != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_exp_left"}, exp_q.size(), 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic wait_outs(input string nm, input int v, input int budget);
    int n = 0;
    while (outs_cnt != 3'(v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, outs_cnt, v);
  endtask

  initial begin : main
    int base;
    int bbase;
    int n;
    rst = 1'b1;
    fifo_empty = 1'b1;
    fifo_data = '0;
    ar_ready = 1'b0;
    r_last_hs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_ar_addr", ar_addr, 0);
    chk("rst_ar_len", ar_len, 0);
    chk("rst_outs", outs_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", desc_done, 0);
    chk("rst_pop", fifo_pop, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Directed descriptors: aligned split, page crossing, zero length.
    rdy_pct = 100; rl_pct = 50;
    push_desc(32'h0000_1000, 32'd256);
    push_desc(32'h0000_1FF0, 32'd64);
    push_desc(32'h0000_4440, 32'd0);
    push_desc(32'hFFFF_FFC0, 32'd128);
    drain("directed", 2000);

    // AR held off for several cycles.
    rdy_pct = 0;
    push_desc(32'h0000_5000, 32'd64);
    n = 0;
    while (!ar_valid && n < 50) begin @(negedge clk); n++; end
    chk("stall_valid_seen", ar_valid, 1);
    base = stab_cnt;
    repeat (6) @(negedge clk);
    chk("stall_hold_cycles", stab_cnt - base >= 5, 1);
    rdy_pct = 100;
    drain("stall", 500);

    // Outstanding limit with 8 full bursts and no retires.
    rl_pct = 0;
    base = ar_cnt;
    push_desc(32'h0000_0000, 32'd1024);
    repeat (40) @(negedge clk);
    chk("limit_outs", outs_cnt, 4);
    chk("limit_ar_cnt", ar_cnt - base, 4);
    chk("limit_valid_low", ar_valid, 0);
    rl_once = 1;
    repeat (8) @(negedge clk);
    chk("fifth_ar_cnt", ar_cnt - base, 5);
    chk("fifth_outs", outs_cnt, 4);
    bbase = both_cnt;
    rl_once = 1; rl_follow = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("same_cycle_ar_cnt", ar_cnt - base, 8);
    chk("same_cycle_both", both_cnt - bbase, 3);
    chk("same_cycle_outs", outs_cnt, 3);
    rl_follow = 0; rl_pct = 50;
    drain("limit", 500);

    // Reset while in ISSUE with three bursts outstanding.
    rl_pct = 0;
    push_desc(32'h0000_3000, 32'd1024);
    wait_outs("pre_rst_outs", 3, 200);
    rdy_pct = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", ar_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ar_valid", ar_valid, 0);
    chk("arst_ar_addr", ar_addr, 0);
    chk("arst_ar_len", ar_len, 0);
    chk("arst_outs", outs_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", desc_done, 0);
    chk("arst_pop", fifo_pop, 0);
    exp_q.delete();
    m_outs = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    rdy_pct = 100; rl_pct = 50;
    push_desc(32'h0000_6FC0, 32'd200);
    drain("post_rst", 1000);

    // Randomized descriptors, including near-page, unaligned and wrapping addresses.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] l;
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = ($urandom & 32'hFFFF_F000) | 32'(12'hF00 + $urandom_range(0, 255));
        2: a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: a = $urandom & 32'h000F_FFF8;
      endcase
      l = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 7))
                                      : 32'($urandom_range(0, 300) * BB + $urandom_range(0, 7));
      rdy_pct = $urandom_range(30, 100);
      rl_pct  = $urandom_range(20, 80);
      push_desc(a, l);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    rl_pct = 50;
    drain("random", 40000);
    chk("final_outs", outs_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
